// File: rtl/alu_bist_driver.sv
// ---------------------------------------------------------------------------
// alu_bist_driver
//
// Built-in self-test engine for the single-cycle datapath ALU. Two 32-bit
// LFSRs generate operand pairs. Each pair is issued with every supported ALU
// opcode: add, sub, and, or, slt. Each result (i_alu_out, i_zero) is folded
// into a 32-bit MISR, and at the end of the run the signature is compared
// against GOLDEN_SIG.
//
// Optional feature macro: ALU_BIST_TRACE_EN
//   When defined, the o_cap_valid and o_cap_idx trace outputs are added.
//
// Ports
//   i_clk        in   1   clock, rising edge
//   i_rst_n      in   1   synchronous reset, active-low
//   i_start      in   1   start request, sampled only in IDLE/DONE
//   o_op_a       out  32  operand A to ALU (registered)
//   o_op_b       out  32  operand B to ALU (registered)
//   o_alu_op     out  3   ALU opcode (registered)
//   i_alu_out    in   32  ALU result
//   i_zero       in   1   ALU zero flag
//   o_busy       out  1   run in progress
//   o_done       out  1   run finished, held until next start
//   o_pass       out  1   valid when o_done: signature == GOLDEN_SIG
//   o_signature  out  32  current MISR value
//   o_cap_valid  out  1   (trace) high during each CAPTURE cycle
//   o_cap_idx    out  3   (trace) op-table index being captured, else 0
// ---------------------------------------------------------------------------
module alu_bist_driver #(
    parameter int unsigned N_VECTORS     = 16,
    parameter logic [31:0] LFSR_SEED     = 32'h0012_3455,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [31:0] GOLDEN_SIG    = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic [31:0] o_op_a,
    output logic [31:0] o_op_b,
    output logic [2:0]  o_alu_op,
    input  logic [31:0] i_alu_out,
    input  logic        i_zero,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [31:0] o_signature
`ifdef ALU_BIST_TRACE_EN
    ,
    output logic        o_cap_valid,
    output logic [2:0]  o_cap_idx
`endif
);

    localparam logic [31:0] POLY     = 32'h0040_0007;
    localparam logic [31:0] SEED_B   = {LFSR_SEED[15:0], LFSR_SEED[31:16]};
    localparam logic [2:0]  LAST_IDX = 3'd4;

    // Counters are at least 1 bit wide so the single-vector and
    // single-settle-cycle configurations still elaborate.
    localparam int unsigned        VEC_W       = (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1;
    localparam int unsigned        SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [VEC_W-1:0]   LAST_VEC    = VEC_W'(N_VECTORS - 1);
    localparam logic [SET_W-1:0]   LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [31:0]        lfsr_a;
    logic [31:0]        lfsr_b;
    logic [31:0]        sig;
    logic [31:0]        sig_next;
    logic [2:0]         idx;
    logic [2:0]         alu_op;
    logic [VEC_W-1:0]   vec;
    logic [SET_W-1:0]   settle_cnt;
    logic               pass;

    // Galois shift used by both the operand LFSRs and the MISR.
    function automatic logic [31:0] gshift(input logic [31:0] r);
        return {r[30:0], 1'b0} ^ (r[31] ? POLY : 32'h0);
    endfunction

    // Op table: idx 0..4 -> add, sub, and, or, slt.
    function automatic logic [2:0] op_code(input logic [2:0] i);
        case (i)
            3'd0:    return 3'b000;
            3'd1:    return 3'b001;
            3'd2:    return 3'b010;
            3'd3:    return 3'b011;
            default: return 3'b101;
        endcase
    endfunction

    assign sig_next = gshift(sig) ^ i_alu_out ^ {31'b0, i_zero};

    // ---- State register ----------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the reset here is synchronous, so it sits
    // inside the clocked branch rather than in the sensitivity list.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // ---- Next-state logic --------------------------------------------------
    // NOTE: the default assignment at the top keeps this purely combinational;
    // omitting it on any path would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (i_start) state_next = S_DRIVE;
            S_DRIVE:        if (settle_cnt == LAST_SETTLE) state_next = S_CAPTURE;
            S_CAPTURE:      state_next = (idx == LAST_IDX && vec == LAST_VEC) ? S_DONE : S_DRIVE;
            default:        state_next = S_IDLE;
        endcase
    end

    // ---- Datapath registers (operands, opcode, counters, MISR) -------------
    // The operand and opcode registers update only on a start, or on the edge
    // leaving CAPTURE. They are therefore stable for the whole settle window.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lfsr_a     <= '0;
            lfsr_b     <= '0;
            sig        <= '0;
            idx        <= '0;
            alu_op     <= '0;
            vec        <= '0;
            settle_cnt <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        lfsr_a     <= LFSR_SEED;
                        lfsr_b     <= SEED_B;
                        sig        <= '0;
                        idx        <= '0;
                        alu_op     <= op_code(3'd0);
                        vec        <= '0;
                        settle_cnt <= '0;
                        pass       <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                S_CAPTURE: begin
                    sig        <= sig_next;
                    settle_cnt <= '0;
                    if (idx != LAST_IDX) begin
                        idx    <= idx + 3'd1;
                        alu_op <= op_code(idx + 3'd1);
                    end else if (vec != LAST_VEC) begin
                        idx    <= '0;
                        alu_op <= op_code(3'd0);
                        vec    <= vec + 1'b1;
                        lfsr_a <= gshift(lfsr_a);
                        lfsr_b <= gshift(lfsr_b);
                    end else begin
                        pass <= (sig_next == GOLDEN_SIG);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---- Output logic ------------------------------------------------------
    always_comb begin
        o_busy = (state == S_DRIVE) || (state == S_CAPTURE);
        o_done = (state == S_DONE);
`ifdef ALU_BIST_TRACE_EN
        o_cap_valid = (state == S_CAPTURE);
        o_cap_idx   = (state == S_CAPTURE) ? idx : 3'd0;
`endif
    end

    assign o_op_a      = lfsr_a;
    assign o_op_b      = lfsr_b;
    assign o_alu_op    = alu_op;
    assign o_pass      = pass;
    assign o_signature = sig;

endmodule
